// File: rtl/rr_arbiter_mux.sv
// rtl/rr_arbiter_mux.sv - N-channel valid/ready mux with fixed-address or round-robin select and a one-entry output register
module rr_arbiter_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          addr,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_last_grant;

    logic                w_load_en;
    logic [SEL_W-1:0]    w_grant;
    logic                w_grant_valid;
    logic [WIDTH-1:0]    w_sel_data;
    logic [CHANNELS-1:0] w_in_ready;
    logic                w_xfer;
    int                  w_idx;

    // Output stage can accept a beat when empty or being drained this cycle
    assign w_load_en = !r_out_valid || out_ready;

    // Grant decision: exact address match in mux mode, first valid after last_grant in RR mode
    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_idx         = 0;
        if (!mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (addr == SEL_W'(i) && in_valid[i]) begin
                    w_grant       = SEL_W'(i);
                    w_grant_valid = 1'b1;
                end
            end
        end else begin
            // Scan furthest offset first so the nearest valid channel after last_grant wins
            for (int k = CHANNELS; k >= 1; k--) begin
                w_idx = (int'(r_last_grant) + k) % CHANNELS;
                if (in_valid[w_idx]) begin
                    w_grant       = SEL_W'(w_idx);
                    w_grant_valid = 1'b1;
                end
            end
        end
    end

    // Steer the granted channel's data and raise only its ready; held low during reset
    always_comb begin
        w_sel_data = '0;
        w_in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_sel_data    = in_data[i*WIDTH +: WIDTH];
                w_in_ready[i] = rst_n && w_load_en && w_grant_valid;
            end
        end
    end

    assign w_xfer = |(w_in_ready & in_valid);

    // Output register: load on transfer (replacing any drained beat), otherwise clear valid on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_chan   <= '0;
            r_last_grant <= SEL_W'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_sel_data;
            r_out_chan   <= w_grant;
            r_last_grant <= w_grant;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arbiter_mux.sv
// tb/tb_rr_arbiter_mux.sv - directed self-checking bench for rr_arbiter_mux
module tb_rr_arbiter_mux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic                      mode;
    logic [SEL_W-1:0]          addr;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_data [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] std_data;

    rr_arbiter_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .addr      (addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b1;
        addr      = '0;
        in_data   = std_data;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        in_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_mux();
        mode      = 1'b0;
        in_data   = std_data;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int a = 0; a < CHANNELS; a++) begin
            addr = SEL_W'(a);
            #1;
            checks++; if (in_ready !== (4'b0001 << a)) begin failures++; $display("FAIL mux_in_ready addr=%0d got=%b exp=%b", a, in_ready, 4'b0001 << a); end
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mux_out_valid addr=%0d got=%b exp=1", a, out_valid); end
            checks++; if (out_data !== exp_data[a]) begin failures++; $display("FAIL mux_out_data addr=%0d got=%h exp=%h", a, out_data, exp_data[a]); end
            checks++; if (out_chan !== SEL_W'(a)) begin failures++; $display("FAIL mux_out_chan addr=%0d got=%0d exp=%0d", a, out_chan, a); end
        end
    endtask

    task automatic test_rr_fairness();
        rst_n = 1'b0;
        #1;
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_out_valid cycle=%0d got=%b exp=1", c, out_valid); end
            checks++; if (out_chan !== SEL_W'(c % 4)) begin failures++; $display("FAIL rr_out_chan cycle=%0d got=%0d exp=%0d", c, out_chan, c % 4); end
            checks++; if (out_data !== exp_data[c % 4]) begin failures++; $display("FAIL rr_out_data cycle=%0d got=%h exp=%h", c, out_data, exp_data[c % 4]); end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [SEL_W-1:0] seq [3];
        seq[0] = 2'd3; seq[1] = 2'd1; seq[2] = 2'd3;
        // force last_grant=2 via a fixed-address transfer
        mode     = 1'b0;
        addr     = 2'd2;
        in_valid = 4'b0100;
        tick();
        checks++; if (out_chan !== 2'd2) begin failures++; $display("FAIL sparse_setup_chan got=%0d exp=2", out_chan); end
        mode     = 1'b1;
        in_valid = 4'b1010;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (in_ready !== (4'b0001 << seq[s])) begin failures++; $display("FAIL sparse_in_ready step=%0d got=%b exp=%b", s, in_ready, 4'b0001 << seq[s]); end
            tick();
            checks++; if (out_chan !== seq[s]) begin failures++; $display("FAIL sparse_out_chan step=%0d got=%0d exp=%0d", s, out_chan, seq[s]); end
            checks++; if (out_data !== exp_data[seq[s]]) begin failures++; $display("FAIL sparse_out_data step=%0d got=%h exp=%h", s, out_data, exp_data[seq[s]]); end
        end
    endtask

    task automatic test_backpressure();
        logic [CHANNELS-1:0] vpat [3];
        vpat[0] = 4'b1111; vpat[1] = 4'b0101; vpat[2] = 4'b0010;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = vpat[c];
            in_data  = {$urandom, $urandom} ;
            mode     = c[0];
            addr     = SEL_W'(c);
            #1;
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0000", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cycle=%0d got=%b exp=1", c, out_valid); end
            checks++; if (out_data !== 8'hD3) begin failures++; $display("FAIL bp_out_data cycle=%0d got=%h exp=d3", c, out_data); end
            checks++; if (out_chan !== 2'd3) begin failures++; $display("FAIL bp_out_chan cycle=%0d got=%0d exp=3", c, out_chan); end
        end
        in_data   = std_data;
        mode      = 1'b1;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=0100", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_reload_valid got=%b exp=1", out_valid); end
        checks++; if (out_chan !== 2'd2) begin failures++; $display("FAIL bp_reload_chan got=%0d exp=2", out_chan); end
        checks++; if (out_data !== 8'hC2) begin failures++; $display("FAIL bp_reload_data got=%h exp=c2", out_data); end
    endtask

    task automatic test_invalid_addr_idle();
        mode      = 1'b0;
        addr      = 2'd2;
        in_valid  = 4'b1011;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL inv_in_ready got=%b exp=0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL inv_drain_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'hC2) begin failures++; $display("FAIL inv_hold_data got=%h exp=c2", out_data); end
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL inv_fix_in_ready got=%b exp=0100", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL inv_fix_valid got=%b exp=1", out_valid); end
        checks++; if (out_chan !== 2'd2) begin failures++; $display("FAIL inv_fix_chan got=%0d exp=2", out_chan); end
        mode     = 1'b1;
        in_valid = 4'b0000;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL idle_in_ready got=%b exp=0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        mode      = 1'b1;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_chan !== 2'd1) begin failures++; $display("FAIL mid_setup got valid=%b chan=%0d exp valid=1 chan=1", out_valid, out_chan); end
        in_valid = 4'b1111;
        rst_n    = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL mid_async_data got=%h exp=00", out_data); end
        checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL mid_async_chan got=%0d exp=0", out_chan); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL mid_async_in_ready got=%b exp=0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_held_valid got=%b exp=0", out_valid); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_rr_ready got=%b exp=0001", in_ready); end
        tick();
        checks++; if (out_chan !== 2'd0 || out_data !== 8'hA0) begin failures++; $display("FAIL mid_first_rr_beat got chan=%0d data=%h exp chan=0 data=a0", out_chan, out_data); end
    endtask

    initial begin
        exp_data[0] = 8'hA0;
        exp_data[1] = 8'hB1;
        exp_data[2] = 8'hC2;
        exp_data[3] = 8'hD3;
        std_data    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        test_reset();
        test_fixed_mux();
        test_rr_fairness();
        test_sparse_wrap();
        test_backpressure();
        test_invalid_addr_idle();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
